// File: rtl/data_write_buffer.sv
// Transmit pattern buffer: four 1-bit lane memories written 32 bits at a time, played back as 4-bit samples.
// Looped playback is built only when DATA_WRITE_LOOP_EN is defined; otherwise every run is one-shot.
module data_write_buffer #(
  parameter int unsigned BUFFER_SIZE = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [1:0]  wr_sel,
  input  logic        wr_en,
  input  logic        start,
  input  logic        stop,
  input  logic [12:0] length,
  input  logic        loop,
  output logic        busy,
  output logic [3:0]  out_data,
  output logic        out_valid,
  output logic        out_last
);

  localparam int unsigned WORDS = BUFFER_SIZE / 32;
  localparam int unsigned PW    = $clog2(BUFFER_SIZE);

  // LOAD is a one-cycle setup slot after start so sample k lands on edge E0+2+k.
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [31:0]   r_mem [4][WORDS];
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_last_ptr;
  logic [12:0]   w_len_eff;
  logic          w_start_ok;
  logic          w_at_end;
  logic          w_wrap;
  logic          w_rd_en;
  logic          w_rd_last;
  logic [3:0]    w_rd_data;

  assign w_len_eff  = (length > 13'(BUFFER_SIZE)) ? 13'(BUFFER_SIZE) : length;
  assign w_start_ok = start && !stop && (w_len_eff != '0);
  assign w_at_end   = (r_ptr == r_last_ptr);

`ifdef DATA_WRITE_LOOP_EN
  logic r_loop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_loop <= 1'b0;
    end else if (r_state == S_IDLE && w_start_ok) begin
      r_loop <= loop;
    end
  end

  assign w_wrap = r_loop;
`else
  logic w_unused_loop;

  assign w_unused_loop = loop;
  assign w_wrap        = 1'b0;
`endif

  // Lane memories are not reset; nonblocking write gives read-before-write on collisions.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_sel][wr_addr] <= wr_data;
    end
  end

  always_comb begin
    w_rd_data = '0;
    for (int unsigned l = 0; l < 4; l++) begin
      w_rd_data[l[1:0]] = r_mem[l[1:0]][r_ptr[PW-1:5]][r_ptr[4:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_next = S_LOAD;
      S_LOAD:  w_next = stop ? S_IDLE : S_RUN;
      S_RUN: begin
        if (stop) begin
          w_next = S_IDLE;
        end else if (w_at_end && !w_wrap) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rd_en   = (r_state == S_RUN) && !stop;
    w_rd_last = w_rd_en && w_at_end && !w_wrap;
  end

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_last_ptr <= '0;
    end else if (r_state == S_IDLE && w_start_ok) begin
      r_ptr      <= '0;
      r_last_ptr <= PW'(w_len_eff - 13'd1);
    end else if (w_rd_en) begin
      r_ptr <= w_at_end ? '0 : r_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= w_rd_en;
      out_last  <= w_rd_last;
      if (w_rd_en) begin
        out_data <= w_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_data_write_buffer.sv
// Directed self-checking bench for data_write_buffer; loop-specific scenarios follow DATA_WRITE_LOOP_EN.
module tb_data_write_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  wr_sel;
  logic        wr_en;
  logic        start;
  logic        stop;
  logic [12:0] length;
  logic        loop;
  logic        busy;
  logic [3:0]  out_data;
  logic        out_valid;
  logic        out_last;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] q_data[$];
  logic       q_last[$];
  int         first_i;
  int         done_i;

  always #5 clk = ~clk;

  data_write_buffer #(.BUFFER_SIZE(4096)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_sel   (wr_sel),
    .wr_en    (wr_en),
    .start    (start),
    .stop     (stop),
    .length   (length),
    .loop     (loop),
    .busy     (busy),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_last (out_last)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [6:0] addr, input logic [31:0] d);
    wr_sel  = sel;
    wr_addr = addr;
    wr_data = d;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  function automatic int count_last();
    int c = 0;
    foreach (q_last[i]) c += int'(q_last[i]);
    return c;
  endfunction

  task automatic capture;
    if (out_valid) begin
      q_data.push_back(out_data);
      q_last.push_back(out_last);
    end
  endtask

  // Starts a run and collects every valid sample until busy falls or the budget expires.
  task automatic play(input logic [12:0] len, input logic lp, input int maxc);
    q_data.delete();
    q_last.delete();
    first_i = -1;
    done_i  = -1;
    length  = len;
    loop    = lp;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    check("busy_after_start", 32'(busy), 1);
    for (int i = 1; i <= maxc; i++) begin
      tick();
      if (out_valid && first_i < 0) first_i = i;
      capture();
      if (!busy) begin
        done_i = i;
        break;
      end
    end
    check("play_completed", 32'(done_i >= 0), 1);
  endtask

  initial begin
    logic [3:0] exp1 [4] = '{4'h1, 4'h0, 4'h1, 4'h0};
    logic [3:0] exp_loop [7] = '{4'h1, 4'h2, 4'h3, 4'h1, 4'h2, 4'h3, 4'h1};
    logic [3:0] exp_col [8] = '{4'h1, 4'h2, 4'h3, 4'h1, 4'h1, 4'h2, 4'h3, 4'h0};
    logic [3:0] exp_k;
    int errs;

    rst_n   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    wr_sel  = '0;
    wr_en   = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    length  = '0;
    loop    = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_last", 32'(out_last), 0);
    check("rst_data", 32'(out_data), 0);
    rst_n = 1'b1;
    tick();

    for (int l = 0; l < 4; l++)
      for (int w = 0; w < 128; w++) wr(2'(l), 7'(w), 32'h0);

    // One-shot: lane 0 word 0 = 5
    wr(2'd0, 7'd0, 32'h5);
    play(13'd4, 1'b0, 20);
    check("t1_count", 32'(q_data.size()), 4);
    for (int k = 0; k < 4 && k < q_data.size(); k++) begin
      check($sformatf("t1_data%0d", k), 32'(q_data[k]), 32'(exp1[k]));
      check($sformatf("t1_last%0d", k), 32'(q_last[k]), 32'(k == 3));
    end
    check("t1_first_edge", 32'(first_i), 2);
    check("t1_idle_edge", 32'(done_i), 6);

    // Lane mapping
    wr(2'd0, 7'd0, 32'h0);
    for (int l = 0; l < 4; l++) wr(2'(l), 7'd1, 32'h1 << l);
    play(13'd64, 1'b0, 100);
    check("lane_count", 32'(q_data.size()), 64);
    errs = 0;
    for (int k = 0; k < q_data.size(); k++) begin
      exp_k = (k >= 32 && k <= 35) ? 4'(1 << (k - 32)) : 4'h0;
      if (q_data[k] !== exp_k) errs++;
    end
    check("lane_sample_errs", 32'(errs), 0);
    if (q_data.size() == 64) begin
      for (int k = 32; k < 36; k++)
        check($sformatf("lane_s%0d", k), 32'(q_data[k]), 32'(1 << (k - 32)));
      check("lane_last63", 32'(q_last[63]), 1);
    end
    check("lane_nlast", 32'(count_last()), 1);

    // Boundary A: zero length rejected
    length = 13'd0;
    loop   = 1'b0;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    check("len0_busy", 32'(busy), 0);
    tick();
    check("len0_busy2", 32'(busy), 0);
    check("len0_valid", 32'(out_valid), 0);

    // Boundary B: length clamps to 4096
    wr(2'd0, 7'd127, 32'h8000_0000);
    play(13'd5000, 1'b0, 4200);
    check("big_count", 32'(q_data.size()), 4096);
    check("big_nlast", 32'(count_last()), 1);
    check("big_idle_edge", 32'(done_i), 4098);
    if (q_data.size() == 4096) begin
      check("big_s4095", 32'(q_data[4095]), 1);
      check("big_last4095", 32'(q_last[4095]), 1);
      check("big_s33", 32'(q_data[33]), 2);
    end

    // Loop and stop: samples 1,2,3
    wr(2'd0, 7'd0, 32'h5);
    wr(2'd1, 7'd0, 32'h6);
`ifdef DATA_WRITE_LOOP_EN
    q_data.delete();
    q_last.delete();
    length = 13'd3;
    loop   = 1'b1;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int i = 1; i <= 40 && q_data.size() < 7; i++) begin
      tick();
      capture();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_valid", 32'(out_valid), 0);
    check("stop_busy", 32'(busy), 0);
    check("loop_count", 32'(q_data.size()), 7);
    for (int k = 0; k < 7 && k < q_data.size(); k++)
      check($sformatf("loop_s%0d", k), 32'(q_data[k]), 32'(exp_loop[k]));
    check("loop_nlast", 32'(count_last()), 0);
`else
    play(13'd3, 1'b1, 20);
    check("noloop_count", 32'(q_data.size()), 3);
    for (int k = 0; k < 3 && k < q_data.size(); k++)
      check($sformatf("noloop_s%0d", k), 32'(q_data[k]), 32'(exp_loop[k]));
    if (q_data.size() == 3) check("noloop_last2", 32'(q_last[2]), 1);
`endif

    // Collision: rewrite lane 0 word 0 while sample 3 is being read
    wr(2'd0, 7'd0, 32'hD);
    q_data.delete();
    q_last.delete();
    length = 13'd4;
`ifdef DATA_WRITE_LOOP_EN
    loop   = 1'b1;
`else
    loop   = 1'b0;
`endif
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (i == 5) begin
        wr_sel  = 2'd0;
        wr_addr = 7'd0;
        wr_data = 32'h5;
        wr_en   = 1'b1;
      end
      tick();
      wr_en = 1'b0;
      capture();
    end
`ifdef DATA_WRITE_LOOP_EN
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("col_count", 32'(q_data.size()), 8);
    for (int k = 0; k < 8 && k < q_data.size(); k++)
      check($sformatf("col_s%0d", k), 32'(q_data[k]), 32'(exp_col[k]));
`else
    check("col_count", 32'(q_data.size()), 4);
    if (q_data.size() == 4) check("col_old_s3", 32'(q_data[3]), 1);
    play(13'd4, 1'b0, 20);
    if (q_data.size() == 4) check("col_new_s3", 32'(q_data[3]), 0);
    check("col_new_count", 32'(q_data.size()), 4);
`endif

    // Asynchronous reset mid-run
    tick();
    length = 13'd64;
    loop   = 1'b0;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int i = 1; i <= 35; i++) tick();
    check("prereset_data", 32'(out_data), 2);
    check("prereset_valid", 32'(out_valid), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_data", 32'(out_data), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_last", 32'(out_last), 0);
    #10;
    rst_n = 1'b1;
    tick();
    play(13'd64, 1'b0, 100);
    check("replay_count", 32'(q_data.size()), 64);
    if (q_data.size() == 64) begin
      for (int k = 32; k < 36; k++)
        check($sformatf("replay_s%0d", k), 32'(q_data[k]), 32'(1 << (k - 32)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/data_write_buffer.md
# data_write_buffer

Transmit-side pattern buffer for the LVDS output lanes. The processor bus writes 32-bit words into four 1-bit-wide lane memories, and a playback engine streams them out as one 4-bit sample per clock. Playback is one-shot or looped. The block sits between the bus register interface and the LVDS serializer, mirroring the receive-side capture buffer.

## Interface
- `BUFFER_SIZE`, 4096: samples per lane (bits per lane memory); fixed at 4096 = 128 words × 32.
- `clk` in 1: single clock for bus writes and playback.
- `rst_n` in 1: reset, asynchronous, active-low.
- `wr_addr` in 7: word index k (0..127) within a lane.
- `wr_data` in 32: bit i becomes sample 32k+i of the selected lane.
- `wr_sel` in 2: lane (0..3) written.
- `wr_en` in 1: write strobe, one word per cycle.
- `start` in 1: single-cycle playback request.
- `stop` in 1: abort playback.
- `length` in 13: samples to play; 0 rejects start; values above 4096 are treated as 4096.
- `loop` in 1: sampled with `start`; 1 = wrap to sample 0 after the last sample until `stop`.
- `busy` out 1: engine not IDLE.
- `out_data` out 4: bit L = lane L sample; registered.
- `out_valid` out 1: `out_data` holds a sample this cycle.
- `out_last` out 1: final sample of a one-shot run; coincident with `out_valid`.

## Operation
- Memory: 4 lanes × 4096 bits. A bus write sets 32 bits of one lane. Contents are not cleared by reset.
- States:
  - **IDLE**
    - `start`=1, `stop`=0, and effective length N≥1 → latch N and loop, ptr=0, go to RUN.
    - Otherwise stay.
  - **RUN**
    - Each cycle, read sample ptr from all 4 lanes; ptr increments.
    - At ptr=N-1 with loop=0 → DRAIN.
    - At ptr=N-1 with loop=1 → ptr wraps to 0 and the engine stays in RUN.
    - `stop`=1 → IDLE immediately; no read is issued that cycle.
    - `start` in RUN is ignored.
  - **DRAIN**: one cycle for the final registered sample, then IDLE.
- Output pipeline: the read issued in cycle c appears on `out_data` in cycle c+1 with `out_valid`=1.
- `out_last`=1 with the sample for ptr=N-1 only when loop=0.
- Stop behaviour: `stop` in RUN forces `out_valid`=0 from the next edge. The sample already read is discarded and `out_last` is not asserted.
- Write/read collision: a write to the word holding the sample read in the same cycle outputs the old value (read-before-write). The new value is seen on the next pass.
- Writes are accepted in every state.

## Timing
- Reset values: `busy`=0, `out_valid`=0, `out_last`=0, `out_data`=0, state IDLE, ptr=0.
- Let E0 be the edge that samples `start`:
  - `busy`=1 after E0.
  - Sample k is on `out_data` after edge E0+2+k.
  - One-shot: `out_last` after edge E0+N+1; `out_valid` and `busy` are 0 after edge E0+N+2.
- Back-to-back runs: `start` is accepted on the first edge where `busy`=0.
- Looped run: sample 0 follows sample N-1 with no gap cycle.
- `rst_n` asserted mid-run: all outputs clear asynchronously, with no `out_last`. Memory contents are kept.

## Configuration
- `DATA_WRITE_LOOP_EN`
  - Defined: `loop` behaves as described above.
  - Undefined: `loop` is ignored, every run is one-shot, and the wrap logic is not built. Playback then ends only by completion, `stop`, or reset.

## Test plan
- One-shot:
  - Stimulus: lane 0 word 0 = 0x0000_0005, other lanes 0; `start` with length=4, loop=0.
  - Response: `out_data` = 1,0,1,0 after edges E0+2..E0+5; `out_last` with the 4th sample; `busy`=0 after E0+6.
- Lane mapping:
  - Stimulus: lane L word 1 = 1<<L for L=0..3; play length=64.
  - Response: samples 32,33,34,35 = 0x1,0x2,0x4,0x8; all other samples 0.
- Loop and stop:
  - Stimulus: loop=1, length=3, samples 0x1,0x2,0x3; `stop` raised after 7 samples.
  - Response: stream 1,2,3,1,2,3,1; no `out_last`; `out_valid`=0 on the edge after `stop`.
- Boundary:
  - Stimulus A: length=0. Response: `busy` stays 0.
  - Stimulus B: length=5000. Response: exactly 4096 samples, ending with sample 4095 (word 127 bit 31) and `out_last`.
- Collision:
  - Stimulus: rewrite word 0 in the cycle sample 3 is read during a looped run.
  - Response: old value on this pass, new value on the next pass.
- Async reset:
  - Stimulus: `rst_n` low mid-run.
  - Response: outputs 0 without waiting for a clock edge; a fresh run after reset replays the unchanged memory.
